// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: applies the 16/8/4/2/1 stages one per clock to a working
// register and pulses data_resultRDY for one cycle when data_result is updated.
module shift_sequencer #(
  parameter int EARLY_EXIT = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_start,
  input  logic [1:0]  ctrl_op,
  input  logic [31:0] data_operand,
  input  logic [4:0]  data_shamt,
  output logic [31:0] data_result,
  output logic        data_resultRDY,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRA = 2'b01;
  localparam logic [1:0] OP_SRL = 2'b10;

  state_t      state_reg, state_next;
  logic [2:0]  cnt_reg, cnt_next;
  logic [31:0] work_reg, work_next;
  logic [1:0]  op_reg, op_next;
  logic [4:0]  shamt_reg, shamt_next;
  logic [31:0] result_reg, result_next;

  // Each stage is a fixed-distance shift, so these are pure wiring plus a 4:1 op mux.
  logic [4:0][31:0] stage_val;

  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_stage
      localparam int AMT = 16 >> gi;
      logic [31:0] sra_val;
      assign sra_val = $unsigned($signed(work_reg) >>> AMT);
      assign stage_val[gi] = (op_reg == OP_SLL) ? (work_reg << AMT) :
                             (op_reg == OP_SRA) ? sra_val :
                             (op_reg == OP_SRL) ? (work_reg >> AMT) :
                             {work_reg[AMT-1:0], work_reg[31:AMT]};
    end
  endgenerate

  logic [31:0] cur_shift;
  logic [31:0] applied;
  logic        stage_en;
  logic [4:0]  rem_low;
  logic        last_stage;

  always_comb begin
    cur_shift = work_reg;
    case (cnt_reg)
      3'd0:    cur_shift = stage_val[0];
      3'd1:    cur_shift = stage_val[1];
      3'd2:    cur_shift = stage_val[2];
      3'd3:    cur_shift = stage_val[3];
      3'd4:    cur_shift = stage_val[4];
      default: cur_shift = work_reg;
    endcase
  end

  // Stage k uses shamt bit 4-k; the bits below it decide whether anything is left to do.
  assign stage_en   = shamt_reg[3'd4 - cnt_reg];
  assign applied    = stage_en ? cur_shift : work_reg;
  assign rem_low    = shamt_reg & ((5'd1 << (3'd4 - cnt_reg)) - 5'd1);
  assign last_stage = (cnt_reg == 3'd4) || ((EARLY_EXIT != 0) && (rem_low == 5'd0));

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    work_next   = work_reg;
    op_next     = op_reg;
    shamt_next  = shamt_reg;
    result_next = result_reg;
    case (state_reg)
      IDLE: begin
        if (ctrl_start) begin
          work_next  = data_operand;
          op_next    = ctrl_op;
          shamt_next = data_shamt;
          cnt_next   = 3'd0;
          if ((EARLY_EXIT != 0) && (data_shamt == 5'd0)) begin
            result_next = data_operand;
            state_next  = DONE;
          end else begin
            state_next = SHIFT;
          end
        end
      end
      SHIFT: begin
        work_next = applied;
        cnt_next  = cnt_reg + 3'd1;
        if (last_stage) begin
          result_next = applied;
          state_next  = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= 3'd0;
      work_reg   <= 32'h0;
      op_reg     <= 2'b00;
      shamt_reg  <= 5'd0;
      result_reg <= 32'h0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      work_reg   <= work_next;
      op_reg     <= op_next;
      shamt_reg  <= shamt_next;
      result_reg <= result_next;
    end
  end

  assign data_result    = result_reg;
  assign data_resultRDY = (state_reg == DONE);
  assign busy           = (state_reg != IDLE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench: two instances (fixed latency and early exit) share data inputs
// but have separate start strobes; latency is counted in rising edges after acceptance.
module tb_shift_sequencer;

  logic        clock;
  logic        reset;
  logic        start0, start1;
  logic [1:0]  ctrl_op;
  logic [31:0] data_operand;
  logic [4:0]  data_shamt;
  logic [31:0] result0, result1;
  logic        rdy0, rdy1, busy0, busy1;

  int total_cnt = 0;
  int pass_cnt  = 0;

  shift_sequencer #(.EARLY_EXIT(0)) dut0 (
    .clock(clock), .reset(reset), .ctrl_start(start0), .ctrl_op(ctrl_op),
    .data_operand(data_operand), .data_shamt(data_shamt),
    .data_result(result0), .data_resultRDY(rdy0), .busy(busy0)
  );

  shift_sequencer #(.EARLY_EXIT(1)) dut1 (
    .clock(clock), .reset(reset), .ctrl_start(start1), .ctrl_op(ctrl_op),
    .data_operand(data_operand), .data_shamt(data_shamt),
    .data_result(result1), .data_resultRDY(rdy1), .busy(busy1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] operand;
    logic [4:0]  shamt;
    logic [31:0] exp;
    int          lat0;
    int          lat1;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Start both instances, scramble the inputs after acceptance, then watch 13 samples.
  task automatic run_vec(input int idx, input vec_t v);
    int lat0, lat1, b0, b1, p0, p1, dbl;
    logic prev0, prev1;
    @(negedge clock);
    ctrl_op = v.op; data_operand = v.operand; data_shamt = v.shamt;
    start0 = 1'b1; start1 = 1'b1;
    @(posedge clock); #1;
    start0 = 1'b0; start1 = 1'b0;
    ctrl_op = ~v.op; data_operand = ~v.operand; data_shamt = ~v.shamt;
    lat0 = -1; lat1 = -1; b0 = 0; b1 = 0; p0 = 0; p1 = 0; dbl = 0;
    prev0 = 1'b0; prev1 = 1'b0;
    for (int c = 0; c <= 12; c++) begin
      if (c > 0) begin @(posedge clock); #1; end
      if (rdy0) begin p0++; if (lat0 < 0) lat0 = c; end
      if (rdy1) begin p1++; if (lat1 < 0) lat1 = c; end
      if (busy0) b0++;
      if (busy1) b1++;
      if ((rdy0 && prev0) || (rdy1 && prev1)) dbl++;
      prev0 = rdy0; prev1 = rdy1;
    end
    $display("vec %0d: op=%0d operand=%h shamt=%0d -> r0=%h lat0=%0d r1=%h lat1=%0d",
             idx, v.op, v.operand, v.shamt, result0, lat0, result1, lat1);
    check($sformatf("vec%0d result0", idx), result0, v.exp);
    check($sformatf("vec%0d result1", idx), result1, v.exp);
    check($sformatf("vec%0d lat0", idx), lat0, v.lat0);
    check($sformatf("vec%0d lat1", idx), lat1, v.lat1);
    check($sformatf("vec%0d busy0_cycles", idx), b0, v.lat0 + 1);
    check($sformatf("vec%0d busy1_cycles", idx), b1, v.lat1 + 1);
    check($sformatf("vec%0d pulses", idx), {p0[15:0], p1[15:0]}, {16'd1, 16'd1});
    check($sformatf("vec%0d rdy_consecutive", idx), dbl, 0);
  endtask

  initial begin
    int p0, t1, t2, hold_bad, any_rdy;
    logic prev;

    vecs[0] = '{2'b01, 32'h8000_0000, 5'd4,  32'hF800_0000, 5, 3};
    vecs[1] = '{2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, 5, 5};
    vecs[2] = '{2'b10, 32'hF000_0000, 5'd28, 32'h0000_000F, 5, 3};
    vecs[3] = '{2'b11, 32'h0000_0001, 5'd1,  32'h8000_0000, 5, 5};
    vecs[4] = '{2'b01, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000, 5, 5};
    vecs[5] = '{2'b01, 32'h1234_5678, 5'd0,  32'h1234_5678, 5, 0};
    vecs[6] = '{2'b00, 32'h0000_00FF, 5'd8,  32'h0000_FF00, 5, 2};
    vecs[7] = '{2'b11, 32'h1234_5678, 5'd12, 32'h6781_2345, 5, 3};
    vecs[8] = '{2'b01, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 5, 5};
    vecs[9] = '{2'b10, 32'hFFFF_FFFF, 5'd16, 32'h0000_FFFF, 5, 1};

    reset = 1'b1; start0 = 1'b0; start1 = 1'b0;
    ctrl_op = 2'b00; data_operand = 32'h0; data_shamt = 5'd0;
    repeat (2) @(posedge clock);
    #1;
    check("reset result0", result0, 32'h0);
    check("reset rdy0", {31'b0, rdy0}, 32'h0);
    check("reset busy0", {31'b0, busy0}, 32'h0);
    check("reset result1", result1, 32'h0);
    check("reset busy1", {31'b0, busy1}, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // Starts during SHIFT and during DONE must be dropped without disturbing the operation.
    @(negedge clock);
    ctrl_op = 2'b10; data_operand = 32'hF000_0000; data_shamt = 5'd4;
    start0 = 1'b1;
    @(posedge clock); #1;
    start0 = 1'b0;
    p0 = 0; t1 = -1; prev = 1'b0; hold_bad = 0;
    for (int c = 0; c <= 12; c++) begin
      if (c > 0) begin @(posedge clock); #1; end
      if (c == 2 || c == 5) begin
        start0 = 1'b1; ctrl_op = 2'b00; data_operand = 32'hFFFF_FFFF; data_shamt = 5'd1;
      end else begin
        start0 = 1'b0;
      end
      if (rdy0) begin p0++; if (t1 < 0) t1 = c; end
      if (rdy0 && prev) hold_bad++;
      prev = rdy0;
    end
    $display("ignore-start: result0=%h pulses=%0d rdy_at=%0d busy0=%0d", result0, p0, t1, busy0);
    check("ignore result", result0, 32'h0F00_0000);
    check("ignore pulses", p0, 1);
    check("ignore latency", t1, 5);
    check("ignore idle_after", {31'b0, busy0}, 32'h0);
    check("ignore rdy_consecutive", hold_bad, 0);

    // Reset asserted while stage 2 is being applied aborts with no RDY.
    @(negedge clock);
    ctrl_op = 2'b00; data_operand = 32'h0000_0001; data_shamt = 5'd31;
    start0 = 1'b1; start1 = 1'b1;
    @(posedge clock); #1;
    start0 = 1'b0; start1 = 1'b0;
    any_rdy = 0;
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) reset = 1'b1;
      @(posedge clock); #1;
      if (rdy0 || rdy1) any_rdy++;
    end
    $display("mid-reset: busy0=%0d result0=%h rdy0=%0d busy1=%0d result1=%h",
             busy0, result0, rdy0, busy1, result1);
    check("midreset busy0", {31'b0, busy0}, 32'h0);
    check("midreset result0", result0, 32'h0);
    check("midreset rdy0", {31'b0, rdy0}, 32'h0);
    check("midreset busy1", {31'b0, busy1}, 32'h0);
    check("midreset result1", result1, 32'h0);
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clock); #1;
      if (rdy0 || rdy1) any_rdy++;
    end
    check("midreset no_rdy", any_rdy, 0);
    run_vec(10, vecs[0]);

    // Back-to-back on the fixed-latency instance: second start in the first IDLE cycle.
    @(negedge clock);
    ctrl_op = 2'b00; data_operand = 32'h0000_0003; data_shamt = 5'd2;
    start0 = 1'b1;
    @(posedge clock); #1;
    start0 = 1'b0;
    t1 = -1; t2 = -1; p0 = 0; hold_bad = 0;
    for (int c = 0; c <= 16; c++) begin
      if (c > 0) begin @(posedge clock); #1; end
      if (rdy0) begin
        p0++;
        if (t1 < 0) t1 = c; else if (t2 < 0) t2 = c;
      end
      if (c >= 5 && c <= 11 && result0 !== 32'h0000_000C) hold_bad++;
      if (c == 6) begin
        start0 = 1'b1; ctrl_op = 2'b10; data_operand = 32'h8000_0000; data_shamt = 5'd1;
      end else begin
        start0 = 1'b0;
      end
    end
    $display("back-to-back: rdy at %0d and %0d, result0=%h", t1, t2, result0);
    check("b2b first_rdy", t1, 5);
    check("b2b second_rdy", t2, 12);
    check("b2b pulses", p0, 2);
    check("b2b hold_first", hold_bad, 0);
    check("b2b second_result", result0, 32'h4000_0000);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
